r88_intctl: RTL and testbench

// Interrupt controller directly upstream of the Rocket88 core: owns the core's irq and nmiReq inputs.

---
 rtl/r88_intctl.sv | 182 ++++++++++++++++++
 tb/tb_r88_intctl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r88_intctl.sv
// rtl/r88_intctl.sv - Rocket88 interrupt controller: sync, latch, mask, priority; NMI path under R88_INTCTL_NMI_EN
module r88_intctl #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          NUM_SRC   = 8
) (
    input  logic               sysClock,
    input  logic               resetReqN,
    input  logic [15:0]        extA,
    input  logic [7:0]         dataIn,
    output logic [7:0]         dataOut,
    output logic               dataOutEn,
    input  logic               readMem,
    input  logic               writeMem,
    input  logic [NUM_SRC-1:0] srcIn,
    input  logic               nmiSrc,
    output logic               irq,
    output logic               nmiReq
);

    localparam logic [15:0] OFF_PEND = 16'd0;
    localparam logic [15:0] OFF_MASK = 16'd1;
    localparam logic [15:0] OFF_MODE = 16'd2;
    localparam logic [15:0] OFF_VECT = 16'd3;
    localparam logic [15:0] OFF_NMI  = 16'd4;

    logic [NUM_SRC-1:0] syncS1;
    logic [NUM_SRC-1:0] syncS2;
    logic [NUM_SRC-1:0] srcPrev;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic               readPrev;
    logic               irqReg;

    logic [15:0]        offset;
    logic               inWindow;
    logic               wrEn;
    logic               ackEn;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] riseDet;
    logic [NUM_SRC-1:0] w1cClr;
    logic [NUM_SRC-1:0] ackClr;
    logic               none;
    logic [2:0]         vectIdx;
    logic               nmiBit;
    logic [7:0]         readData;

    // Address decode: the subtraction only means something once extA is at or above the base.
    assign offset    = extA - BASE_ADDR;
    assign inWindow  = (extA >= BASE_ADDR) && (offset <= OFF_NMI);
    assign wrEn      = writeMem && inWindow;

    assign active    = pend & mask;
    assign none      = (active == '0);
    assign riseDet   = syncS2 & ~srcPrev;

    // Only the first cycle of a VECT read acknowledges, so a multi-cycle access cannot eat two sources.
    assign ackEn     = readMem && inWindow && (offset == OFF_VECT) && !readPrev && !none;
    assign w1cClr    = (wrEn && (offset == OFF_PEND)) ? dataIn[NUM_SRC-1:0] : '0;

    // Lowest-index pending and enabled source wins; idx stays 0 when nothing is active.
    always_comb begin
        vectIdx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                vectIdx = i[2:0];
            end
        end
    end

    // One-hot clear request for the source being acknowledged.
    always_comb begin
        ackClr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ackClr[i] = ackEn && (vectIdx == i[2:0]);
        end
    end

    // Two-flop synchroniser plus the previous-value flop used for rising-edge detection.
    always_ff @(posedge sysClock) begin
        if (!resetReqN) begin
            syncS1  <= '0;
            syncS2  <= '0;
            srcPrev <= '0;
        end else begin
            syncS1  <= srcIn;
            syncS2  <= syncS1;
            srcPrev <= syncS2;
        end
    end

    // Level bits mirror the synchronised source; edge bits latch rising edges, and a new edge beats any clear.
    always_ff @(posedge sysClock) begin
        if (!resetReqN) begin
            pend <= '0;
        end else begin
            pend <= (~mode & syncS2) | (mode & (riseDet | (pend & ~(w1cClr | ackClr))));
        end
    end

    // Software-visible MASK and MODE registers; MODE resets to all-edge.
    always_ff @(posedge sysClock) begin
        if (!resetReqN) begin
            mask <= '0;
            mode <= '1;
        end else begin
            if (wrEn && (offset == OFF_MASK)) begin
                mask <= dataIn[NUM_SRC-1:0];
            end
            if (wrEn && (offset == OFF_MODE)) begin
                mode <= dataIn[NUM_SRC-1:0];
            end
        end
    end

    // Registered request to the core and the read-strobe history used to find the first access cycle.
    always_ff @(posedge sysClock) begin
        if (!resetReqN) begin
            irqReg   <= 1'b0;
            readPrev <= 1'b0;
        end else begin
            irqReg   <= !none;
            readPrev <= readMem;
        end
    end

    assign irq = irqReg;

`ifdef R88_INTCTL_NMI_EN
    logic nmiS1;
    logic nmiS2;
    logic nmiPrev;
    logic nmiLatch;
    logic nmiReqReg;
    logic nmiClr;

    assign nmiClr = wrEn && (offset == OFF_NMI) && dataIn[0];

    // NMI: synchronise, latch rising edges until software clears, then register towards the core.
    always_ff @(posedge sysClock) begin
        if (!resetReqN) begin
            nmiS1     <= 1'b0;
            nmiS2     <= 1'b0;
            nmiPrev   <= 1'b0;
            nmiLatch  <= 1'b0;
            nmiReqReg <= 1'b0;
        end else begin
            nmiS1     <= nmiSrc;
            nmiS2     <= nmiS1;
            nmiPrev   <= nmiS2;
            nmiLatch  <= (nmiS2 & ~nmiPrev) | (nmiLatch & ~nmiClr);
            nmiReqReg <= nmiLatch;
        end
    end

    assign nmiReq = nmiReqReg;
    assign nmiBit = nmiLatch;
`else
    logic unusedNmi;

    assign unusedNmi = nmiSrc;
    assign nmiReq    = 1'b0;
    assign nmiBit    = 1'b0;
`endif

    // Register read mux; bits above NUM_SRC read as zero.
    always_comb begin
        readData = 8'h00;
        case (offset)
            OFF_PEND: readData[NUM_SRC-1:0] = active;
            OFF_MASK: readData[NUM_SRC-1:0] = mask;
            OFF_MODE: readData[NUM_SRC-1:0] = mode;
            OFF_VECT: readData = {none, 4'b0000, vectIdx};
            OFF_NMI:  readData = {7'b0000000, nmiBit};
            default:  readData = 8'h00;
        endcase
    end

    assign dataOutEn = readMem && inWindow;
    assign dataOut   = dataOutEn ? readData : 8'h00;

endmodule

// File: tb/tb_r88_intctl.sv
// tb/tb_r88_intctl.sv - directed and randomized bench for r88_intctl
module tb_r88_intctl;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        sysClock = 1'b0;
    logic        resetReqN;
    logic [15:0] extA;
    logic [7:0]  dataIn;
    logic [7:0]  dataOut;
    logic        dataOutEn;
    logic        readMem;
    logic        writeMem;
    logic [7:0]  srcIn;
    logic        nmiSrc;
    logic        irq;
    logic        nmiReq;

    int total = 0;
    int bad   = 0;

    r88_intctl #(.BASE_ADDR(BASE), .NUM_SRC(8)) dut (
        .sysClock (sysClock),
        .resetReqN(resetReqN),
        .extA     (extA),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .dataOutEn(dataOutEn),
        .readMem  (readMem),
        .writeMem (writeMem),
        .srcIn    (srcIn),
        .nmiSrc   (nmiSrc),
        .irq      (irq),
        .nmiReq   (nmiReq)
    );

    always #5 sysClock = ~sysClock;

    // Reference model: sources seen through a history queue (index 0 = sample at this edge).
    logic [7:0] srcQ[$];
    logic       nmiQ[$];
    logic [7:0] mPend = 8'h00, mMask = 8'h00, mMode = 8'hFF;
    logic       mIrq = 1'b0, mNmiLatch = 1'b0, mNmiReq = 1'b0, mReadPrev = 1'b0;

    always @(posedge sysClock) begin
        int         off;
        logic       inWin;
        logic [7:0] act, rise, clr, nPend;
        logic       nRise;
        srcQ.push_front(srcIn);
        nmiQ.push_front(nmiSrc);
        if (srcQ.size() > 6) void'(srcQ.pop_back());
        if (nmiQ.size() > 6) void'(nmiQ.pop_back());
        if (!resetReqN) begin
            srcQ = '{8'h00, 8'h00, 8'h00, 8'h00};
            nmiQ = '{1'b0, 1'b0, 1'b0, 1'b0};
            mPend = 8'h00; mMask = 8'h00; mMode = 8'hFF;
            mIrq = 1'b0; mNmiLatch = 1'b0; mNmiReq = 1'b0; mReadPrev = 1'b0;
        end else begin
            off   = int'(extA) - int'(BASE);
            inWin = (off >= 0) && (off <= 4);
            act   = mPend & mMask;
            rise  = srcQ[2] & ~srcQ[3];
            clr   = 8'h00;
            if (writeMem && inWin && off == 0) clr = dataIn;
            if (readMem && inWin && off == 3 && !mReadPrev && act != 8'h00)
                clr = clr | (act & (~act + 8'd1));
            nPend = (~mMode & srcQ[2]) | (mMode & (rise | (mPend & ~clr)));
            mIrq  = (act != 8'h00);
            if (writeMem && inWin && off == 1) mMask = dataIn;
            if (writeMem && inWin && off == 2) mMode = dataIn;
            mPend = nPend;
            mReadPrev = readMem;
`ifdef R88_INTCTL_NMI_EN
            nRise     = nmiQ[2] & ~nmiQ[3];
            mNmiReq   = mNmiLatch;
            mNmiLatch = nRise | (mNmiLatch & ~(writeMem && inWin && off == 4 && dataIn[0]));
`else
            nRise = 1'b0;
`endif
        end
    end

    function automatic logic [7:0] mRead(input int off);
        logic [7:0] act;
        logic [7:0] v;
        act = mPend & mMask;
        v = 8'h00;
        case (off)
            0: v = act;
            1: v = mMask;
            2: v = mMode;
            3: begin
                v = 8'h80;
                for (int i = 7; i >= 0; i--) if (act[i]) v = 8'(i);
            end
            4: v = {7'b0, mNmiLatch};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic busWrite(input int off, input logic [7:0] d);
        extA = BASE + 16'(off); dataIn = d; writeMem = 1'b1;
        @(negedge sysClock);
        writeMem = 1'b0;
    endtask

    task automatic busRead(input int off, output logic [7:0] d);
        extA = BASE + 16'(off); readMem = 1'b1;
        #1 d = dataOut;
        @(negedge sysClock);
        readMem = 1'b0;
        @(negedge sysClock);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        resetReqN = 1'b0; srcIn = 8'hFF;
        repeat (2) @(negedge sysClock);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
        total++; if (nmiReq !== 1'b0) begin bad++; $display("FAIL reset_nmi got=%b want=0", nmiReq); end
        resetReqN = 1'b1;
        busRead(1, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_mask got=%h want=00", d); end
        busRead(2, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL reset_mode got=%h want=FF", d); end
        busRead(0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h want=00", d); end
        srcIn = 8'h00;
        repeat (4) @(negedge sysClock);
        busWrite(0, 8'hFF);
        busRead(3, d);
        total++; if (d !== 8'h80) begin bad++; $display("FAIL reset_vect got=%h want=80", d); end
    endtask

    task automatic test_edge_latency();
        logic [7:0] d;
        busWrite(1, 8'h04);
        srcIn = 8'h04; @(negedge sysClock);
        srcIn = 8'h00; @(negedge sysClock);
        @(negedge sysClock);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL lat_irq_k2 got=%b want=0", irq); end
        @(negedge sysClock);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL lat_irq_k3 got=%b want=1", irq); end
        extA = BASE + 16'd3; readMem = 1'b1;
        #1 total++; if (dataOut !== 8'h02) begin bad++; $display("FAIL lat_vect got=%h want=02", dataOut); end
        @(negedge sysClock);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL lat_irq_ack got=%b want=1", irq); end
        #1 total++; if (dataOut !== 8'h80) begin bad++; $display("FAIL lat_vect2 got=%h want=80", dataOut); end
        @(negedge sysClock);
        readMem = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL lat_irq_clr got=%b want=0", irq); end
        @(negedge sysClock);
        // Two pending sources: a held read must acknowledge only once.
        busWrite(1, 8'h14);
        srcIn = 8'h14; @(negedge sysClock);
        srcIn = 8'h00; repeat (3) @(negedge sysClock);
        extA = BASE + 16'd3; readMem = 1'b1;
        #1 total++; if (dataOut !== 8'h02) begin bad++; $display("FAIL hold_vect1 got=%h want=02", dataOut); end
        @(negedge sysClock);
        #1 total++; if (dataOut !== 8'h04) begin bad++; $display("FAIL hold_vect2 got=%h want=04", dataOut); end
        @(negedge sysClock);
        #1 total++; if (dataOut !== 8'h04) begin bad++; $display("FAIL hold_vect3 got=%h want=04", dataOut); end
        @(negedge sysClock);
        readMem = 1'b0; @(negedge sysClock);
        busRead(3, d);
        total++; if (d !== 8'h04) begin bad++; $display("FAIL hold_vect4 got=%h want=04", d); end
        busRead(3, d);
        total++; if (d !== 8'h80) begin bad++; $display("FAIL hold_vect5 got=%h want=80", d); end
    endtask

    task automatic test_priority();
        logic [7:0] d;
        busWrite(1, 8'hFF);
        srcIn = 8'h22; @(negedge sysClock);
        srcIn = 8'h00; repeat (3) @(negedge sysClock);
        busRead(3, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL prio_1 got=%h want=01", d); end
        busRead(3, d);
        total++; if (d !== 8'h05) begin bad++; $display("FAIL prio_5 got=%h want=05", d); end
        busRead(3, d);
        total++; if (d !== 8'h80) begin bad++; $display("FAIL prio_none got=%h want=80", d); end
    endtask

    task automatic test_level();
        logic [7:0] d;
        busWrite(2, 8'hFE);
        busWrite(1, 8'h01);
        srcIn = 8'h01; repeat (4) @(negedge sysClock);
        busRead(0, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL lvl_pend got=%h want=01", d); end
        busWrite(0, 8'h01);
        busRead(0, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL lvl_w1c got=%h want=01", d); end
        busRead(3, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL lvl_vect got=%h want=00", d); end
        busRead(3, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL lvl_ack got=%h want=00", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq got=%b want=1", irq); end
        srcIn = 8'h00; extA = BASE; readMem = 1'b1;
        @(negedge sysClock);
        @(negedge sysClock);
        #1 total++; if (dataOut !== 8'h01) begin bad++; $display("FAIL lvl_k1 got=%h want=01", dataOut); end
        @(negedge sysClock);
        #1 total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL lvl_k2 got=%h want=00", dataOut); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_irq_k2 got=%b want=1", irq); end
        @(negedge sysClock);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_irq_k3 got=%b want=0", irq); end
        readMem = 1'b0; @(negedge sysClock);
        busWrite(2, 8'hFF);
    endtask

    task automatic test_collision();
        logic [7:0] d;
        busWrite(1, 8'h08);
        srcIn = 8'h08; @(negedge sysClock);
        @(negedge sysClock);
        busWrite(0, 8'h08);
        busRead(0, d);
        total++; if (d !== 8'h08) begin bad++; $display("FAIL coll_pend got=%h want=08", d); end
        busWrite(5, 8'h00);
        busWrite(-1, 8'hFF);
        extA = BASE + 16'd5; readMem = 1'b1;
        #1 total++; if (dataOutEn !== 1'b0) begin bad++; $display("FAIL oow_en got=%b want=0", dataOutEn); end
        total++; if (dataOut !== 8'h00) begin bad++; $display("FAIL oow_data got=%h want=00", dataOut); end
        @(negedge sysClock); readMem = 1'b0; @(negedge sysClock);
        busRead(1, d);
        total++; if (d !== 8'h08) begin bad++; $display("FAIL oow_mask got=%h want=08", d); end
        busRead(2, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL oow_mode got=%h want=FF", d); end
        busRead(0, d);
        total++; if (d !== 8'h08) begin bad++; $display("FAIL oow_pend got=%h want=08", d); end
        extA = BASE + 16'd1; dataIn = 8'h0A; readMem = 1'b1; writeMem = 1'b1;
        #1 total++; if (dataOut !== 8'h08) begin bad++; $display("FAIL rw_old got=%h want=08", dataOut); end
        @(negedge sysClock); readMem = 1'b0; writeMem = 1'b0; @(negedge sysClock);
        busRead(1, d);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL rw_new got=%h want=0A", d); end
        busWrite(0, 8'h08);
        busRead(0, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL coll_clr got=%h want=00", d); end
        srcIn = 8'h00; repeat (3) @(negedge sysClock);
    endtask

    task automatic test_nmi();
        logic [7:0] d;
`ifdef R88_INTCTL_NMI_EN
        nmiSrc = 1'b1; @(negedge sysClock);
        @(negedge sysClock);
        @(negedge sysClock);
        total++; if (nmiReq !== 1'b0) begin bad++; $display("FAIL nmi_k2 got=%b want=0", nmiReq); end
        @(negedge sysClock);
        total++; if (nmiReq !== 1'b1) begin bad++; $display("FAIL nmi_k3 got=%b want=1", nmiReq); end
        nmiSrc = 1'b0; repeat (3) @(negedge sysClock);
        total++; if (nmiReq !== 1'b1) begin bad++; $display("FAIL nmi_hold got=%b want=1", nmiReq); end
        busRead(4, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL nmi_reg got=%h want=01", d); end
        busWrite(4, 8'h01);
        @(negedge sysClock);
        total++; if (nmiReq !== 1'b0) begin bad++; $display("FAIL nmi_clr got=%b want=0", nmiReq); end
        busRead(4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL nmi_reg_clr got=%h want=00", d); end
`else
        nmiSrc = 1'b1; repeat (4) @(negedge sysClock);
        total++; if (nmiReq !== 1'b0) begin bad++; $display("FAIL nmi_off got=%b want=0", nmiReq); end
        nmiSrc = 1'b0;
        busRead(4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL nmi_off_reg got=%h want=00", d); end
        busWrite(4, 8'h01);
        busRead(4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL nmi_off_wr got=%h want=00", d); end
`endif
    endtask

    task automatic test_random();
        int         op;
        int         off;
        logic       inWin;
        logic [7:0] expData;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 2) == 0) srcIn = 8'($urandom);
            if ($urandom_range(0, 7) == 0) nmiSrc = ~nmiSrc;
            op = $urandom_range(0, 9);
            readMem = 1'b0; writeMem = 1'b0;
            if (op >= 4) begin
                if (op < 7) readMem = 1'b1;
                else if (op < 9) writeMem = 1'b1;
                else begin readMem = 1'b1; writeMem = 1'b1; end
                if (writeMem || $urandom_range(0, 1) == 0)
                    extA = ($urandom_range(0, 9) == 0) ? BASE - 16'd1 : BASE + 16'($urandom_range(0, 5));
                dataIn = 8'($urandom);
            end
            #1;
            off     = int'(extA) - int'(BASE);
            inWin   = (off >= 0) && (off <= 4);
            expData = (readMem && inWin) ? mRead(off) : 8'h00;
            total++; if (dataOutEn !== (readMem && inWin)) begin bad++; $display("FAIL rnd_en c=%0d got=%b want=%b", c, dataOutEn, readMem && inWin); end
            total++; if (dataOut !== expData) begin bad++; $display("FAIL rnd_data c=%0d off=%0d got=%h want=%h", c, off, dataOut, expData); end
            total++; if (irq !== mIrq) begin bad++; $display("FAIL rnd_irq c=%0d got=%b want=%b", c, irq, mIrq); end
            total++; if (nmiReq !== mNmiReq) begin bad++; $display("FAIL rnd_nmi c=%0d got=%b want=%b", c, nmiReq, mNmiReq); end
            @(negedge sysClock);
        end
        readMem = 1'b0; writeMem = 1'b0;
        @(negedge sysClock);
    endtask

    initial begin
        resetReqN = 1'b0; extA = 16'h0000; dataIn = 8'h00;
        readMem = 1'b0; writeMem = 1'b0; srcIn = 8'h00; nmiSrc = 1'b0;
        @(negedge sysClock);
        test_reset();
        test_edge_latency();
        test_priority();
        test_level();
        test_collision();
        test_nmi();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
